hpdcache_flush_all_sequencer: RTL and testbench
===============================================

// Module: hpdcache_flush_all_sequencer
// PURPOSE
//  Sequences a cache-wide flush: walks every set of the HPDcache directory, finds dirty ways,
//  feeds their line addresses into the flush controller's ALLOC interface and clears their dirty bits.
//  Sits between the cache control/CMO logic and the flush controller. It shares the directory read
//  port with the main pipeline through a request/grant pair. Signals completion once the flush
//  controller has drained.
// PARAMETERS
//  Sets      64  number of directory sets; power of 2, >= 2
//  Ways      8   associativity; >= 1
//  TagWidth  20  tag bits per way; nline = {tag, set}, width TagWidth+$clog2(Sets)
// PORTS
//  clk_i               in   1                   clock
//  rst_ni              in   1                   async reset, active low
//  start_i             in   1                   1-cycle pulse: begin flush-all
//  busy_o              out  1                   sequence in progress (start_i accepted .. done_o)
//  done_o              out  1                   1-cycle pulse: all dirty lines written back
//  dir_rd_req_o        out  1                   request directory read of dir_rd_set_o
//  dir_rd_gnt_i        in   1                   read granted this cycle
//  dir_rd_set_o        out  $clog2(Sets)        set to read
//  dir_rd_dirty_i      in   Ways                dirty&valid mask, valid 1 cycle after grant
//  dir_rd_tags_i       in   Ways*TagWidth       way tags (way w at [w*TagWidth +: TagWidth]), same timing
//  dir_clr_dirty_o     out  1                   clear dirty bit of (dir_rd_set_o, dir_clr_way_o)
//  dir_clr_way_o       out  $clog2(Ways) (min 1) way to clear
//  flush_alloc_o       out  1                   allocate flush entry
//  flush_alloc_nline_o out  TagWidth+$clog2(Sets) line address to flush
//  flush_full_i        in   1                   flush controller cannot accept alloc
//  flush_empty_i       in   1                   flush controller has no pending entries
// BEHAVIOUR
//  Reset: FSM=IDLE; set counter=0; dirty mask=0; all outputs 0.
//  FSM states:
//   IDLE: start_i -> READ, set counter=0, busy_o=1 from next cycle. start_i while busy is ignored.
//   READ: dir_rd_req_o=1 with dir_rd_set_o=set counter; hold until dir_rd_gnt_i -> CAPT.
//   CAPT: latch dir_rd_dirty_i/dir_rd_tags_i into internal mask/tag regs -> SCAN.
//   SCAN: w = lowest set bit of mask.
//    - mask!=0 && !flush_full_i: flush_alloc_o=1, nline={tag[w],set}; dir_clr_dirty_o=1, way=w,
//      in the same cycle; clear mask bit w. One line per cycle max.
//    - mask!=0 && flush_full_i: stall, no alloc, no clear, mask unchanged.
//    - mask==0 && set!=Sets-1: set++ -> READ.
//    - mask==0 && set==Sets-1: -> DRAIN (no wrap; counter is not reused).
//   DRAIN: wait flush_empty_i=1 -> IDLE with done_o=1 for that cycle, busy_o=0 next cycle.
//  flush_alloc_o and dir_clr_dirty_o are always asserted together and only in SCAN.
//  dir_rd_set_o holds the current set from READ through SCAN (valid for clear).
//  Clean set costs 3 cycles (READ w/ immediate grant, CAPT, SCAN). A dirty set costs 3 + #dirty
//  cycles plus full stalls. Min total with 0 dirty lines: 3*Sets + 1 (DRAIN) cycles.
//  Mask is a snapshot. Pipeline writes to the same set after CAPT are not re-scanned (owner blocks them).
//  Reset mid-sequence: immediate return to IDLE, no done_o; partially flushed state left as is.
//  Simultaneous start_i and done_o cycle: start_i ignored (FSM not IDLE that cycle).
// TESTING
//  T1 all clean, Sets=4, gnt always 1, flush_empty_i=1: start -> 0 allocs, done_o at cycle 13, busy 12 cycles.
//  T2 set 2 dirty=8'b1000_0101, tags 0x11/0x22/0x33 in ways 0/2/7 -> allocs nline {0x11,2},{0x22,2},{0x33,2}
//     on 3 consecutive cycles, clears on ways 0,2,7 same cycles.
//  T3 T2 with flush_full_i=1 for 5 cycles after first alloc -> no alloc/clear during those 5 cycles, then
//     remaining 2 lines, no loss or duplicate.
//  T4 dir_rd_gnt_i withheld 10 cycles on set 1 -> dir_rd_req_o/set=1 held stable, sequence then continues.
//  T5 flush_empty_i=0 for 20 cycles after last set -> busy_o stays 1, done_o exactly once when it rises.
//  T6 rst_ni low during SCAN of set 3 -> all outputs 0 next; new start_i restarts at set 0; start_i while busy ignored.

Source files
------------

// File: rtl/hpdcache_flush_all_sequencer.sv
// rtl/hpdcache_flush_all_sequencer.sv - cache-wide flush sequencer: scans directory sets, issues dirty lines to flush controller
module hpdcache_flush_all_sequencer #(
    parameter int unsigned Sets     = 64,
    parameter int unsigned Ways     = 8,
    parameter int unsigned TagWidth = 20,
    localparam int unsigned SetW    = $clog2(Sets),
    localparam int unsigned WayW    = (Ways > 1) ? $clog2(Ways) : 1,
    localparam int unsigned NlineW  = TagWidth + SetW
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     dir_rd_req_o,
    input  logic                     dir_rd_gnt_i,
    output logic [SetW-1:0]          dir_rd_set_o,
    input  logic [Ways-1:0]          dir_rd_dirty_i,
    input  logic [Ways*TagWidth-1:0] dir_rd_tags_i,
    output logic                     dir_clr_dirty_o,
    output logic [WayW-1:0]          dir_clr_way_o,
    output logic                     flush_alloc_o,
    output logic [NlineW-1:0]        flush_alloc_nline_o,
    input  logic                     flush_full_i,
    input  logic                     flush_empty_i
);

    typedef enum logic [2:0] {IDLE, READ, CAPT, SCAN, DRAIN} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [SetW-1:0]           set_cnt;
    logic [Ways-1:0]           mask;
    logic [Ways*TagWidth-1:0]  tags;
    logic [WayW-1:0]           way;
    logic [TagWidth-1:0]       tag_sel;
    logic                      last_set;
    logic                      issue;

    assign last_set = (set_cnt == SetW'(Sets - 1));
    assign issue    = (state == SCAN) && (mask != '0) && !flush_full_i;
    assign tag_sel  = tags[way*TagWidth +: TagWidth];

    // Lowest dirty way first; scanning downward lets the lowest index win.
    always_comb begin
        way = '0;
        for (int i = Ways - 1; i >= 0; i--) begin
            if (mask[i]) way = WayW'(i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            set_cnt <= '0;
            mask    <= '0;
            tags    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start_i) set_cnt <= '0;
                CAPT: begin
                    mask <= dir_rd_dirty_i;
                    tags <= dir_rd_tags_i;
                end
                SCAN: begin
                    if (issue) begin
                        mask <= mask & (mask - Ways'(1));
                    end else if ((mask == '0) && !last_set) begin
                        set_cnt <= set_cnt + SetW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_i) state_nxt = READ;
            READ:  if (dir_rd_gnt_i) state_nxt = CAPT;
            CAPT:  state_nxt = SCAN;
            SCAN:  if (mask == '0) state_nxt = last_set ? DRAIN : READ;
            DRAIN: if (flush_empty_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o              = (state != IDLE);
        done_o              = (state == DRAIN) && flush_empty_i;
        dir_rd_req_o        = (state == READ);
        dir_rd_set_o        = ((state == READ) || (state == CAPT) || (state == SCAN)) ? set_cnt : '0;
        flush_alloc_o       = issue;
        dir_clr_dirty_o     = issue;
        dir_clr_way_o       = issue ? way : '0;
        flush_alloc_nline_o = issue ? {tag_sel, set_cnt} : '0;
    end

endmodule

// File: tb/tb_hpdcache_flush_all_sequencer.sv
// tb/tb_hpdcache_flush_all_sequencer.sv - randomized self-checking bench with directory/flush reference model
module tb_hpdcache_flush_all_sequencer;

    localparam int SETS = 4;
    localparam int WAYS = 8;
    localparam int TW   = 20;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_i = 1'b0;
    logic            busy_o, done_o, dir_rd_req_o;
    logic            dir_rd_gnt_i = 1'b0;
    logic [1:0]      dir_rd_set_o;
    logic [WAYS-1:0] dir_rd_dirty_i = '0;
    logic [WAYS*TW-1:0] dir_rd_tags_i = '0;
    logic            dir_clr_dirty_o;
    logic [2:0]      dir_clr_way_o;
    logic            flush_alloc_o;
    logic [TW+1:0]   flush_alloc_nline_o;
    logic            flush_full_i = 1'b0;
    logic            flush_empty_i = 1'b1;

    hpdcache_flush_all_sequencer #(.Sets(SETS), .Ways(WAYS), .TagWidth(TW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .dir_rd_req_o(dir_rd_req_o), .dir_rd_gnt_i(dir_rd_gnt_i), .dir_rd_set_o(dir_rd_set_o),
        .dir_rd_dirty_i(dir_rd_dirty_i), .dir_rd_tags_i(dir_rd_tags_i),
        .dir_clr_dirty_o(dir_clr_dirty_o), .dir_clr_way_o(dir_clr_way_o),
        .flush_alloc_o(flush_alloc_o), .flush_alloc_nline_o(flush_alloc_nline_o),
        .flush_full_i(flush_full_i), .flush_empty_i(flush_empty_i)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference directory and expected flush order
    logic [WAYS-1:0] dirty_m [SETS];
    logic [TW-1:0]   tag_m   [SETS][WAYS];
    logic [31:0]     exp_nline[$];
    logic [31:0]     exp_way[$];

    int gnt_pct = 100, full_pct = 0, empty_pct = 100, rstart_pct = 0;
    int full_hold = 0, empty_hold = 0, blk_n = 0, blk_set = -1;
    bit full_trig = 0, start_req = 0, pend_rd = 0, prev_stall = 0;
    int pend_set = 0, rd_idx = 0, cyc = 0;
    logic [1:0] prev_set = '0;
    int done_cnt, alloc_cnt, done_step, start_step, busy_pre, nexp;
    int alloc_steps[$];
    logic [31:0] first_nline;

    task automatic step();
        @(negedge clk);
        start_i = start_req || (busy_o && ($urandom_range(0, 99) < rstart_pct));
        start_req = 0;
        if (dir_rd_req_o && (int'(dir_rd_set_o) == blk_set) && blk_n > 0) begin
            dir_rd_gnt_i = 0;
            blk_n--;
        end else begin
            dir_rd_gnt_i = ($urandom_range(0, 99) < gnt_pct);
        end
        if (pend_rd) begin
            dir_rd_dirty_i = dirty_m[pend_set];
            for (int w = 0; w < WAYS; w++) dir_rd_tags_i[w*TW +: TW] = tag_m[pend_set][w];
        end else begin
            dir_rd_dirty_i = WAYS'($urandom);
            for (int w = 0; w < WAYS; w++) dir_rd_tags_i[w*TW +: TW] = TW'($urandom);
        end
        if (full_hold > 0) begin
            flush_full_i = 1;
            full_hold--;
        end else begin
            flush_full_i = ($urandom_range(0, 99) < full_pct);
        end
        if (empty_hold > 0 && rd_idx == SETS && exp_nline.size() == 0) begin
            flush_empty_i = 0;
            empty_hold--;
        end else begin
            flush_empty_i = ($urandom_range(0, 99) < empty_pct);
        end
        pend_rd = 0;
        #1;
        cyc++;
        chk("alloc_eq_clr", 32'(flush_alloc_o), 32'(dir_clr_dirty_o));
        if (prev_stall) begin
            chk("req_hold", 32'(dir_rd_req_o), 32'd1);
            chk("set_hold", 32'(dir_rd_set_o), 32'(prev_set));
        end
        if (dir_rd_req_o) begin
            chk("rd_set", 32'(dir_rd_set_o), rd_idx);
            if (dir_rd_gnt_i) begin
                pend_rd = 1;
                pend_set = int'(dir_rd_set_o);
                rd_idx++;
            end
        end
        prev_stall = dir_rd_req_o && !dir_rd_gnt_i;
        prev_set = dir_rd_set_o;
        if (flush_alloc_o) begin
            logic [31:0] en, ew;
            en = exp_nline.size() > 0 ? exp_nline.pop_front() : 32'hFFFF_FFFF;
            ew = exp_way.size() > 0 ? exp_way.pop_front() : 32'hFFFF_FFFF;
            chk("alloc_not_full", 32'(flush_full_i), 32'd0);
            chk("alloc_nline", 32'(flush_alloc_nline_o), en);
            chk("clr_way", 32'(dir_clr_way_o), ew);
            if (alloc_cnt == 0) first_nline = 32'(flush_alloc_nline_o);
            if (alloc_cnt == 0 && full_trig) full_hold = 5;
            alloc_cnt++;
            alloc_steps.push_back(cyc);
            dirty_m[dir_rd_set_o][dir_clr_way_o] = 1'b0;
        end
        if (done_o) begin
            done_cnt++;
            done_step = cyc;
            chk("done_empty", 32'(flush_empty_i), 32'd1);
            chk("done_pending", exp_nline.size(), 32'd0);
            chk("done_reads", rd_idx, SETS);
        end
        if (busy_o && !done_o && done_cnt == 0) busy_pre++;
    endtask

    task automatic build_exp();
        exp_nline.delete();
        exp_way.delete();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (dirty_m[s][w]) begin
                    exp_nline.push_back((32'(tag_m[s][w]) << 2) | 32'(s));
                    exp_way.push_back(32'(w));
                end
        nexp = exp_nline.size();
    endtask

    task automatic begin_run();
        build_exp();
        rd_idx = 0; done_cnt = 0; alloc_cnt = 0; busy_pre = 0;
        alloc_steps.delete();
        start_req = 1;
        step();
        start_step = cyc;
    endtask

    task automatic run_flush(input string name);
        int n;
        int left;
        begin_run();
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            step();
            n++;
        end
        chk({name, "_done_seen"}, done_cnt, 1);
        chk({name, "_alloc_cnt"}, alloc_cnt, nexp);
        for (int k = 0; k < 3; k++) step();
        chk({name, "_busy_after"}, 32'(busy_o), 32'd0);
        chk({name, "_done_once"}, done_cnt, 1);
        left = 0;
        for (int s = 0; s < SETS; s++) left += $countones(dirty_m[s]);
        chk({name, "_dirty_left"}, left, 0);
    endtask

    task automatic fill_dir(input int pct);
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                dirty_m[s][w] = ($urandom_range(0, 99) < pct);
                tag_m[s][w] = TW'($urandom);
            end
    endtask

    initial begin
        fill_dir(0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_req", 32'(dir_rd_req_o), 32'd0);
        chk("rst_alloc", 32'(flush_alloc_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        rst_ni = 1;

        // all clean, ideal handshakes: fixed latency
        run_flush("t1");
        chk("t1_latency", done_step - start_step, 3 * SETS + 1);
        chk("t1_busy", busy_pre, 3 * SETS);

        // three dirty ways in set 2, back-to-back allocs
        fill_dir(0);
        dirty_m[2] = 8'b1000_0101;
        tag_m[2][0] = 20'h11; tag_m[2][2] = 20'h22; tag_m[2][7] = 20'h33;
        run_flush("t2");
        chk("t2_first", first_nline, {10'd0, 20'h11, 2'd2});
        if (alloc_steps.size() == 3) chk("t2_consec", alloc_steps[2] - alloc_steps[0], 2);
        else chk("t2_nallocs", alloc_steps.size(), 3);

        // same with the flush queue full for 5 cycles after the first alloc
        dirty_m[2] = 8'b1000_0101;
        full_trig = 1;
        run_flush("t3");
        full_trig = 0;
        if (alloc_steps.size() == 3) chk("t3_gap", alloc_steps[1] - alloc_steps[0], 6);
        else chk("t3_nallocs", alloc_steps.size(), 3);

        // grant withheld 10 cycles on set 1
        fill_dir(30);
        blk_set = 1; blk_n = 10; rstart_pct = 10;
        run_flush("t4");
        chk("t4_blk_used", blk_n, 0);
        blk_set = -1; rstart_pct = 0;

        // drain held off for 20 cycles
        fill_dir(0);
        empty_hold = 20;
        run_flush("t5");
        chk("t5_latency", done_step - start_step, 3 * SETS + 1 + 18);

        // reset while stalled in SCAN of set 3
        fill_dir(0);
        dirty_m[3] = 8'b0110_0000;
        full_pct = 100;
        begin_run();
        for (int n = 0; n < 200 && rd_idx < SETS; n++) step();
        step();
        step();
        chk("t6_in_scan", 32'(dir_rd_set_o), 32'd3);
        @(negedge clk);
        rst_ni = 0;
        #1;
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_set", 32'(dir_rd_set_o), 32'd0);
        chk("t6_alloc", 32'(flush_alloc_o | dir_clr_dirty_o), 32'd0);
        chk("t6_req_done", 32'(dir_rd_req_o | done_o), 32'd0);
        @(negedge clk);
        rst_ni = 1;
        pend_rd = 0; prev_stall = 0; full_pct = 0;
        rstart_pct = 10;
        run_flush("t6");

        // randomized traffic
        gnt_pct = 70; full_pct = 30; empty_pct = 60; rstart_pct = 5;
        for (int it = 0; it < 6; it++) begin
            fill_dir(25);
            run_flush("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
